// File: rtl/stream_fifo.sv
// Stream FIFO: buffers a valid-only write stream and presents it first-word
// fall-through on a valid/ready port, with level, almost-full and sticky overflow.
module stream_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enIn,
    input  logic [WIDTH-1:0]           dataIn,
    output logic                       validOut,
    input  logic                       readyIn,
    output logic [WIDTH-1:0]           dataOut,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almostFull,
    output logic                       overflow,
    input  logic                       clrOverflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             almost_full_q, almost_full_d;
    logic             full, empty, push, pop;

    // Next-state: a pop frees a slot that a same-edge write may reuse when full.
    always_comb begin
        full          = (level_q == LW'(DEPTH));
        empty         = (level_q == '0);
        pop           = !empty && readyIn;
        push          = enIn && (!full || pop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        overflow_d    = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (clrOverflow) begin
            overflow_d = 1'b0;
        end
        if (enIn && full && !pop) begin
            overflow_d = 1'b1;
        end
        almost_full_d = (level_d >= LW'(AF_LEVEL));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Storage is never reset; level gating keeps stale entries off dataOut.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    assign validOut   = (level_q != '0);
    assign dataOut    = validOut ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign almostFull = almost_full_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries; legal values are powers of 2 and at least 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default 6, giving the almost-full threshold; legal range is 1 to DEPTH.
REQ-004 Port clk: input, 1 bit, the single clock; all state SHALL change on the rising edge.
REQ-005 Port reset: input, 1 bit; reset is asynchronous and active-high.
REQ-006 Port enIn: input, 1 bit; a write strobe with no backpressure.
REQ-007 Port dataIn: input, WIDTH bits; the write data, qualified by enIn.
REQ-008 Port validOut: output, 1 bit; the head entry is valid.
REQ-009 Port readyIn: input, 1 bit; the consumer accepts the head entry.
REQ-010 Port dataOut: output, WIDTH bits; the head entry (first-word fall-through).
REQ-011 Port level: output, log2(DEPTH)+1 bits; the current number of stored entries.
REQ-012 Port almostFull: output, 1 bit; high when level >= AF_LEVEL.
REQ-013 Port overflow: output, 1 bit; a sticky flag marking that write data was dropped.
REQ-014 Port clrOverflow: input, 1 bit; a synchronous clear for overflow.

Function
REQ-015 The block SHALL buffer a valid-only stream (enIn/dataIn, no backpressure) and present it on a valid/ready interface, in order and without duplication.
REQ-016 Push: the block SHALL write dataIn on a rising edge where enIn=1 and the FIFO is not full, or is full but a pop occurs on the same edge.
REQ-017 Pop: the block SHALL remove the head entry on a rising edge where validOut=1 and readyIn=1; readyIn while validOut=0 SHALL have no effect.
REQ-018 validOut SHALL equal (level != 0) and SHALL be registered-state derived, with no combinational path from readyIn or enIn.
REQ-019 dataOut SHALL equal the head entry while validOut=1, and SHALL be all-zero while validOut=0.
REQ-020 Latency: data written on edge N SHALL appear on validOut/dataOut after edge N when the FIFO was empty, giving 1 cycle of latency and no bypass path.
REQ-021 On a simultaneous push and pop, level SHALL be unchanged; this SHALL also hold when full, where the freed slot accepts the new write.
REQ-022 A push when full without a pop SHALL drop dataIn, leave contents and level unchanged, and set overflow to 1 on that edge.
REQ-023 overflow SHALL stay set until clrOverflow=1 or reset.
REQ-024 If clrOverflow=1 coincides with a new overflow event, overflow SHALL be 1 after the edge; set wins.
REQ-025 The read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 silently.
REQ-026 Full/empty SHALL be distinguished by level, or by one extra pointer wrap bit.
REQ-027 level SHALL never exceed DEPTH and SHALL never underflow below 0.
REQ-028 almostFull SHALL be registered-state derived and SHALL update on the same edge as level.
REQ-029 Storage contents SHALL not be reset; no output may expose un-written storage.

Reset
REQ-030 While reset=1, regardless of clk, the block SHALL clear the pointers, level and overflow, so that validOut=0, dataOut=0, level=0, almostFull=0 and overflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries.
REQ-032 enIn/readyIn asserted while reset=1 SHALL be ignored.
REQ-033 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Basic: reset, then enIn=1 with dataIn=0x11,0x22,0x33 over 3 cycles, readyIn=0 -> level=3, validOut=1, dataOut=0x11; then readyIn=1 for 3 cycles -> outputs 0x11,0x22,0x33 in order, then validOut=0 and dataOut=0.
REQ-035 Full/overflow: push 9 words 0x1..0x9 with readyIn=0 and DEPTH=8 -> level=8, almostFull=1 from level 6, overflow=1 after the 9th push, and draining yields 0x1..0x8 only.
REQ-036 Full with simultaneous push+pop: at level=8, enIn=1 with dataIn=0xA5 and readyIn=1 -> level stays 8, overflow stays 0, and 0xA5 emerges last.
REQ-037 Wrap-around: stream 20 consecutive words with readyIn=1 continuously -> level alternates 0/1 at most, all 20 words are output in order, and the pointers wrap at least twice.
REQ-038 Overflow clear race: clrOverflow=1 on the same edge as a dropped push -> overflow=1; clrOverflow=1 alone next cycle -> overflow=0.
REQ-039 Async reset mid-stream: reset pulse of less than 1 cycle between edges at level=5 -> level=0, validOut=0 and overflow=0 immediately, and the next push 0x77 is output alone.
